// File: rtl/i2c_slave_rx_if.sv
// i2c_slave_rx_if: bus pins and receive-FIFO read port of the i2c_slave_rx target.
// Ports: scl_in/sda_in (bus), sda_out (open-drain ACK drive), rx_data/rx_valid/rx_ready
//        (FIFO read), busy/addr_match/stop_det/rx_overflow/fifo_count (status).
interface i2c_slave_rx_if #(
    parameter int FIFO_DEPTH = 8
);
    logic                          scl_in;
    logic                          sda_in;
    logic                          sda_out;
    logic [7:0]                    rx_data;
    logic                          rx_valid;
    logic                          rx_ready;
    logic                          busy;
    logic                          addr_match;
    logic                          stop_det;
    logic                          rx_overflow;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;

    // Target side (the i2c_slave_rx block).
    modport slave (
        input  scl_in, sda_in, rx_ready,
        output sda_out, rx_data, rx_valid, busy, addr_match, stop_det,
               rx_overflow, fifo_count
    );

    // Bus master / FIFO consumer side.
    modport master (
        output scl_in, sda_in, rx_ready,
        input  sda_out, rx_data, rx_valid, busy, addr_match, stop_det,
               rx_overflow, fifo_count
    );
endinterface

// File: rtl/i2c_slave_rx.sv
// i2c_slave_rx: receive-only I2C target; ACKs writes to SLAVE_ADDR and queues data bytes in a FWFT FIFO.
// Ports: core_clk, rst (async active-high), bus (i2c_slave_rx_if.slave: SCL/SDA in, SDA drive out,
//        valid/ready FIFO read port, status). Push-to-rx_valid latency 1 core_clk.
// Optional: define I2C_SLAVE_GENERAL_CALL_EN to also ACK the general-call address byte 8'h00.
module i2c_slave_rx #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h78,
    parameter int         FIFO_DEPTH  = 8,
    parameter int         SYNC_STAGES = 2
) (
    input  logic          core_clk,
    input  logic          rst,
    i2c_slave_rx_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_DATA, ST_DATA_ACK, ST_IGNORE
    } state_t;

    // ---------------- input synchronisers and edge/condition detect ----------------
    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_prev, sda_prev;
    logic                   scl_cur, sda_cur;

    always_ff @(posedge core_clk or posedge rst) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda_in};
            scl_prev <= scl_sync[SYNC_STAGES-1];
            sda_prev <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl_cur = scl_sync[SYNC_STAGES-1];
    assign sda_cur = sda_sync[SYNC_STAGES-1];

    logic scl_rise, scl_fall, start_cond, stop_cond;
    assign scl_rise   = scl_cur & ~scl_prev;
    assign scl_fall   = ~scl_cur & scl_prev;
    // SCL must be high in both samples so an SDA change next to an SCL edge is not misread.
    assign start_cond = scl_cur & scl_prev & sda_prev & ~sda_cur;
    assign stop_cond  = scl_cur & scl_prev & ~sda_prev & sda_cur;

    // ---------------- FSM state ----------------
    state_t     state;
    logic [3:0] bit_cnt;
    logic [7:0] shreg;
    logic       ack_q, sda_q, busy_q, match_q, stop_q, ovf_q;

    // ---------------- FIFO ----------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          full, pop, byte_done, push, addr_ok;

    assign full      = (count == FULL_CNT);
    assign pop       = (count != '0) && bus.rx_ready;
    // A byte completes on the 8th SCL fall in DATA; START/STOP need SCL high so cannot coincide.
    assign byte_done = (state == ST_DATA) && scl_fall && (bit_cnt == 4'd8);
    assign push      = byte_done && (!full || pop);

`ifdef I2C_SLAVE_GENERAL_CALL_EN
    assign addr_ok = (shreg == {SLAVE_ADDR, 1'b0}) || (shreg == 8'h00);
`else
    assign addr_ok = (shreg == {SLAVE_ADDR, 1'b0});
`endif

    always_ff @(posedge core_clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            ack_q   <= 1'b0;
            sda_q   <= 1'b1;
            busy_q  <= 1'b0;
            match_q <= 1'b0;
            stop_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            stop_q <= 1'b0;
            if (stop_cond) begin
                state   <= ST_IDLE;
                busy_q  <= 1'b0;
                match_q <= 1'b0;
                sda_q   <= 1'b1;
                stop_q  <= 1'b1;
                bit_cnt <= '0;
            end else if (start_cond) begin
                // Also covers repeated START: any partial byte is simply abandoned.
                state   <= ST_ADDR;
                busy_q  <= 1'b1;
                match_q <= 1'b0;
                sda_q   <= 1'b1;
                bit_cnt <= '0;
            end else begin
                case (state)
                    ST_IDLE: ;
                    ST_ADDR, ST_DATA: begin
                        if (scl_rise && bit_cnt != 4'd8) begin
                            shreg   <= {shreg[6:0], sda_cur};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            if (state == ST_ADDR) begin
                                state   <= ST_ADDR_ACK;
                                ack_q   <= addr_ok;
                                sda_q   <= ~addr_ok;
                                match_q <= addr_ok;
                            end else begin
                                state <= ST_DATA_ACK;
                                ack_q <= push;
                                sda_q <= ~push;
                                if (!push) ovf_q <= 1'b1;
                            end
                        end
                    end
                    ST_ADDR_ACK, ST_DATA_ACK: begin
                        if (scl_fall) begin
                            sda_q   <= 1'b1;
                            bit_cnt <= '0;
                            state   <= ack_q ? ST_DATA : ST_IGNORE;
                        end
                    end
                    ST_IGNORE: sda_q <= 1'b1;
                    default:   state <= ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge core_clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge core_clk) begin
        if (push) mem[wr_ptr] <= shreg;
    end

    assign bus.sda_out     = sda_q;
    assign bus.rx_valid    = (count != '0);
    assign bus.rx_data     = (count != '0) ? mem[rd_ptr] : 8'h00;
    assign bus.busy        = busy_q;
    assign bus.addr_match  = match_q;
    assign bus.stop_det    = stop_q;
    assign bus.rx_overflow = ovf_q;
    assign bus.fifo_count  = count;
endmodule

// File: tb/tb_i2c_slave_rx.sv
// Bench for i2c_slave_rx: bit-level I2C master, wired-AND SDA, queue-based reference model.
module tb_i2c_slave_rx;
    localparam int DEPTH = 8;
    localparam logic [7:0] OWN_W = 8'hF0;
    localparam int Q = 40;  // quarter SCL period in ns (SCL = 16 core_clk)

    logic core_clk = 1'b0;
    logic rst = 1'b1;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;
    always #5 core_clk = ~core_clk;

    i2c_slave_rx_if #(.FIFO_DEPTH(DEPTH)) bus ();
    assign bus.scl_in = scl_m;
    assign bus.sda_in = sda_m & bus.sda_out;

    i2c_slave_rx #(.SLAVE_ADDR(7'h78), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
        .core_clk (core_clk),
        .rst      (rst),
        .bus      (bus)
    );

    int checks = 0;
    int errors = 0;
    int stop_cnt = 0;
    int stop_long = 0;
    logic stop_last = 1'b0;

    always @(posedge core_clk) begin
        if (bus.stop_det === 1'b1) stop_cnt++;
        if (bus.stop_det === 1'b1 && stop_last) stop_long++;
        stop_last = (bus.stop_det === 1'b1);
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    logic [7:0] mq[$];
    logic       m_ovf;
    logic [7:0] dbuf [16];

    // Expected ACK vector for one write transaction: bit 0 = address, bit i = data byte i-1.
    task automatic model_xfer(input logic [7:0] addr, input int n, output logic [16:0] exp);
        logic ok, alive;
        exp = '0;
        ok = (addr == OWN_W);
`ifdef I2C_SLAVE_GENERAL_CALL_EN
        ok = ok || (addr == 8'h00);
`endif
        exp[0] = ok;
        alive = ok;
        for (int i = 0; i < n; i++) begin
            if (alive) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back(dbuf[i]);
                    exp[i+1] = 1'b1;
                end else begin
                    m_ovf = 1'b1;
                    alive = 1'b0;
                end
            end
        end
    endtask

    // ---------------- bus master ----------------
    task automatic bit_out(input logic b);
        sda_m = b; #Q; scl_m = 1'b1; #(2*Q); scl_m = 1'b0; #Q;
    endtask

    task automatic ack_clk(output logic acked);
        sda_m = 1'b1; #Q; scl_m = 1'b1; #Q;
        acked = (bus.sda_out === 1'b0);
        #Q; scl_m = 1'b0; #Q;
    endtask

    task automatic byte_out(input logic [7:0] b, output logic acked);
        for (int i = 7; i >= 0; i--) bit_out(b[i]);
        ack_clk(acked);
    endtask

    task automatic bus_start;
        sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; sda_m = 1'b0; #Q; scl_m = 1'b0; #Q;
    endtask

    task automatic bus_stop;
        sda_m = 1'b0; #Q; scl_m = 1'b1; #Q; sda_m = 1'b1; #Q; #Q;
    endtask

    task automatic send(input logic [7:0] addr, input int n, output logic [16:0] got);
        logic a;
        got = '0;
        bus_start;
        byte_out(addr, a);
        got[0] = a;
        for (int i = 0; i < n; i++) begin
            byte_out(dbuf[i], a);
            got[i+1] = a;
        end
    endtask

    task automatic do_reset;
        @(negedge core_clk);
        rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; bus.rx_ready = 1'b0;
        repeat (3) @(negedge core_clk);
        rst = 1'b0;
        @(negedge core_clk);
        mq.delete();
        m_ovf = 1'b0;
    endtask

    // Pops everything with random ready, comparing each head byte with the model queue.
    task automatic drain(input string tag);
        logic rdy;
        for (int c = 0; c < 200 && mq.size() != 0; c++) begin
            @(negedge core_clk);
            checks++;
            if (bus.rx_valid !== 1'b1 || bus.rx_data !== mq[0] || bus.fifo_count !== mq.size()) begin
                errors++;
                $display("FAIL %s drain: valid=%b data=%h count=%0d, expected valid=1 data=%h count=%0d",
                         tag, bus.rx_valid, bus.rx_data, bus.fifo_count, mq[0], mq.size());
            end
            rdy = 1'($urandom_range(0, 1));
            bus.rx_ready = rdy;
            if (rdy) void'(mq.pop_front());
        end
        @(negedge core_clk);
        bus.rx_ready = 1'b0;
        checks++;
        if (bus.rx_valid !== 1'b0 || bus.fifo_count !== mq.size()) begin
            errors++;
            $display("FAIL %s drain_empty: valid=%b count=%0d, expected valid=0 count=%0d",
                     tag, bus.rx_valid, bus.fifo_count, mq.size());
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        do_reset;
        checks++;
        if ({bus.sda_out, bus.rx_valid, bus.rx_data, bus.busy, bus.addr_match,
             bus.stop_det, bus.rx_overflow} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs: sda=%b valid=%b data=%h busy=%b match=%b stop=%b ovf=%b, expected 1 0 00 0 0 0 0",
                     bus.sda_out, bus.rx_valid, bus.rx_data, bus.busy, bus.addr_match,
                     bus.stop_det, bus.rx_overflow);
        end
        checks++;
        if (bus.fifo_count !== 0) begin
            errors++;
            $display("FAIL reset_count: got %0d expected 0", bus.fifo_count);
        end
    endtask

    task automatic test_fill;
        logic [16:0] exp, got;
        int s0;
        do_reset;
        for (int i = 0; i < 8; i++) dbuf[i] = 8'(i + 1);
        model_xfer(OWN_W, 8, exp);
        s0 = stop_cnt;
        send(OWN_W, 8, got);
        checks++;
        if (got !== exp) begin
            errors++; $display("FAIL fill_acks: got %h expected %h", got, exp);
        end
        checks++;
        if (bus.fifo_count !== mq.size() || bus.rx_data !== mq[0]) begin
            errors++;
            $display("FAIL fill_fifo: count=%0d data=%h expected count=%0d data=%h",
                     bus.fifo_count, bus.rx_data, mq.size(), mq[0]);
        end
        checks++;
        if ({bus.busy, bus.addr_match, bus.rx_overflow} !== {1'b1, 1'b1, m_ovf}) begin
            errors++;
            $display("FAIL fill_status: busy/match/ovf=%b%b%b expected 11%b",
                     bus.busy, bus.addr_match, bus.rx_overflow, m_ovf);
        end
        bus_stop;
        checks++;
        if (bus.busy !== 1'b0 || bus.addr_match !== 1'b0 || stop_cnt - s0 !== 1) begin
            errors++;
            $display("FAIL fill_stop: busy=%b match=%b stop_pulses=%0d expected 0 0 1",
                     bus.busy, bus.addr_match, stop_cnt - s0);
        end
        drain("fill");
    endtask

    task automatic test_overflow;
        logic [16:0] exp, got;
        do_reset;
        for (int i = 0; i < 10; i++) dbuf[i] = 8'(i + 1);
        model_xfer(OWN_W, 10, exp);
        send(OWN_W, 10, got);
        checks++;
        if (got !== exp) begin
            errors++; $display("FAIL ovf_acks: got %h expected %h", got, exp);
        end
        checks++;
        if (bus.rx_overflow !== m_ovf || bus.fifo_count !== mq.size() || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL ovf_status: ovf=%b count=%0d busy=%b expected ovf=%b count=%0d busy=1",
                     bus.rx_overflow, bus.fifo_count, bus.busy, m_ovf, mq.size());
        end
        bus_stop;
        drain("ovf");
        checks++;
        if (bus.rx_overflow !== m_ovf) begin
            errors++; $display("FAIL ovf_sticky: got %b expected %b", bus.rx_overflow, m_ovf);
        end
        do_reset;
        checks++;
        if (bus.rx_overflow !== m_ovf) begin
            errors++; $display("FAIL ovf_clear: got %b expected %b", bus.rx_overflow, m_ovf);
        end
    endtask

    task automatic test_bad_addr;
        logic [7:0] addrs [2];
        logic [16:0] exp, got;
        addrs[0] = 8'hE0;
        addrs[1] = 8'hF1;
        do_reset;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 3; i++) dbuf[i] = 8'($urandom);
            model_xfer(addrs[k], 3, exp);
            send(addrs[k], 3, got);
            checks++;
            if (got !== exp || bus.addr_match !== exp[0] || bus.fifo_count !== mq.size()) begin
                errors++;
                $display("FAIL bad_addr_%h: acks=%h match=%b count=%0d expected acks=%h match=%b count=%0d",
                         addrs[k], got, bus.addr_match, bus.fifo_count, exp, exp[0], mq.size());
            end
            bus_stop;
        end
    endtask

    task automatic test_repeated_start;
        logic [16:0] e1, g1, e2, g2;
        do_reset;
        dbuf[0] = 8'hAA;
        model_xfer(OWN_W, 1, e1);
        send(OWN_W, 1, g1);
        bit_out(1'b1); bit_out(1'b0); bit_out(1'b1); bit_out(1'b1);
        dbuf[0] = 8'h55;
        model_xfer(OWN_W, 1, e2);
        send(OWN_W, 1, g2);
        checks++;
        if (g1 !== e1 || g2 !== e2) begin
            errors++;
            $display("FAIL rstart_acks: got %h/%h expected %h/%h", g1, g2, e1, e2);
        end
        checks++;
        if (bus.fifo_count !== mq.size() || bus.addr_match !== e2[0]) begin
            errors++;
            $display("FAIL rstart_count: count=%0d match=%b expected %0d %b",
                     bus.fifo_count, bus.addr_match, mq.size(), e2[0]);
        end
        bus_stop;
        drain("rstart");
    endtask

    task automatic test_rst_mid;
        logic [16:0] exp, got;
        do_reset;
        dbuf[0] = 8'hC3;
        model_xfer(OWN_W, 0, exp);
        send(OWN_W, 0, got);
        for (int i = 7; i >= 0; i--) bit_out(dbuf[0][i]);
        model_xfer(OWN_W, 1, exp);  // address already counted; this stages the pushed byte
        // 9th clock: SCL high, target should be holding SDA low
        sda_m = 1'b1; #Q; scl_m = 1'b1; #Q;
        checks++;
        if (bus.sda_out !== 1'b0 || bus.fifo_count !== mq.size()) begin
            errors++;
            $display("FAIL rstmid_pre: sda=%b count=%0d expected sda=0 count=%0d",
                     bus.sda_out, bus.fifo_count, mq.size());
        end
        rst = 1'b1;
        mq.delete();
        m_ovf = 1'b0;
        #1;
        checks++;
        if (bus.sda_out !== 1'b1 || bus.fifo_count !== mq.size() || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async: sda=%b count=%0d busy=%b expected sda=1 count=%0d busy=0",
                     bus.sda_out, bus.fifo_count, bus.busy, mq.size());
        end
        #(Q-1); scl_m = 1'b0; #Q;
        rst = 1'b0;
        #Q;
        dbuf[0] = 8'h3C;
        model_xfer(OWN_W, 1, exp);
        send(OWN_W, 1, got);
        checks++;
        if (got !== exp) begin
            errors++; $display("FAIL rstmid_after: acks %h expected %h", got, exp);
        end
        bus_stop;
        drain("rstmid");
    endtask

    task automatic test_random;
        logic [16:0] exp, got;
        logic [7:0]  addr;
        int n;
        do_reset;
        for (int it = 0; it < 18; it++) begin
            case ($urandom_range(0, 5))
                0, 1:    addr = OWN_W;
                2:       addr = 8'hF1;
                3:       addr = 8'hE0;
                4:       addr = 8'h00;
                default: addr = 8'($urandom);
            endcase
            n = $urandom_range(0, 10);
            for (int i = 0; i < n; i++) dbuf[i] = 8'($urandom);
            model_xfer(addr, n, exp);
            send(addr, n, got);
            checks++;
            if (got !== exp || bus.addr_match !== exp[0]) begin
                errors++;
                $display("FAIL rand_%0d_acks: addr=%h acks=%h match=%b expected acks=%h match=%b",
                         it, addr, got, bus.addr_match, exp, exp[0]);
            end
            bus_stop;
            checks++;
            if (bus.fifo_count !== mq.size() || bus.rx_overflow !== m_ovf || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL rand_%0d_state: count=%0d ovf=%b busy=%b expected count=%0d ovf=%b busy=0",
                         it, bus.fifo_count, bus.rx_overflow, bus.busy, mq.size(), m_ovf);
            end
            if ($urandom_range(0, 2) == 0) drain("rand");
        end
        drain("rand_end");
        checks++;
        if (stop_long !== 0) begin
            errors++; $display("FAIL stop_pulse_width: long pulses=%0d expected 0", stop_long);
        end
    endtask

    initial begin
        bus.rx_ready = 1'b0;
        m_ovf = 1'b0;
        test_reset;
        test_fill;
        test_overflow;
        test_bad_addr;
        test_repeated_start;
        test_rst_mid;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
